// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the sysid checker.
// FSM states, sysid word addresses, timeout width.
package soc_system_sysid_pkg;

  localparam int TMO_W = 16;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ID   = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_RD_TS   = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/soc_system_sysid_timeout.sv
// Per-transaction cycle counter for the sysid checker.
// Ports: clear/enable/limit in, expired out (comb).
module soc_system_sysid_timeout
  import soc_system_sysid_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] cnt;

  // Flags on the limit-th enabled cycle so the
  // owner can leave on the same edge.
  assign expired = enable &&
                   (cnt >= limit - TMO_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Reads sysid ID (and timestamp with SYSID_CHECK_TIMESTAMP_EN)
// over Avalon-MM and reports pass/timeout. Ports: start, avm_*, busy/done/pass/timeout_err, id_out/ts_out.
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_out,
  output logic [31:0] ts_out
);

`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam logic [TMO_W-1:0] LIMIT =
    TMO_W'(TIMEOUT_CYCLES);
  localparam state_t AFTER_ID =
    TS_EN ? ST_RD_TS : ST_FINISH;

  state_t state, state_n;
  logic   cap_id, cap_ts, set_tmo, clr;
  logic   in_rd, in_txn, expired;
  logic   id_ok, ts_ok;

  assign in_rd  = (state == ST_RD_ID) ||
                  (state == ST_RD_TS);
  assign in_txn = in_rd ||
                  (state == ST_WAIT_ID) ||
                  (state == ST_WAIT_TS);

  soc_system_sysid_timeout u_tmo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clr),
    .enable  (in_txn),
    .limit   (LIMIT),
    .expired (expired)
  );

  // Drop the request on the expiry cycle so no
  // command is accepted that we then abandon.
  assign avm_read    = in_rd && !expired;
  assign avm_address =
    ((state == ST_RD_TS) || (state == ST_WAIT_TS)) ?
    SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FINISH);

  assign id_ok = (id_out == EXPECTED_ID);
  assign ts_ok = !TS_EN || (ts_out == EXPECTED_TS);

  always_comb begin
    state_n = state;
    cap_id  = 1'b0;
    cap_ts  = 1'b0;
    set_tmo = 1'b0;
    clr     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RD_ID;
          clr     = 1'b1;
        end
      end
      ST_RD_ID: begin
        if (expired) begin
          set_tmo = 1'b1;
          state_n = ST_FINISH;
        end else if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            cap_id  = 1'b1;
            state_n = AFTER_ID;
            clr     = TS_EN;
          end else begin
            state_n = ST_WAIT_ID;
          end
        end
      end
      ST_WAIT_ID: begin
        if (avm_readdatavalid) begin
          cap_id  = 1'b1;
          state_n = AFTER_ID;
          clr     = TS_EN;
        end else if (expired) begin
          set_tmo = 1'b1;
          state_n = ST_FINISH;
        end
      end
      ST_RD_TS: begin
        if (expired) begin
          set_tmo = 1'b1;
          state_n = ST_FINISH;
        end else if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            cap_ts  = 1'b1;
            state_n = ST_FINISH;
          end else begin
            state_n = ST_WAIT_TS;
          end
        end
      end
      ST_WAIT_TS: begin
        if (avm_readdatavalid) begin
          cap_ts  = 1'b1;
          state_n = ST_FINISH;
        end else if (expired) begin
          set_tmo = 1'b1;
          state_n = ST_FINISH;
        end
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      id_out      <= '0;
      ts_out      <= '0;
    end else begin
      state <= state_n;
      if ((state == ST_IDLE) && start) begin
        pass        <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (set_tmo) timeout_err <= 1'b1;
      if (cap_id)  id_out <= avm_readdata;
      if (cap_ts)  ts_out <= avm_readdata;
      if (state == ST_FINISH)
        pass <= id_ok && ts_ok && !timeout_err;
    end
  end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Randomized bench for soc_system_sysid_checker.
// Scripted Avalon slave plus transaction-level model.
module tb_soc_system_sysid_checker;

`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam logic [31:0] EXP_ID = 32'hB0D5_0002;
  localparam logic [31:0] EXP_TS = 32'h6502_1A3C;
  localparam int          LIMIT  = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        wr;
  logic [31:0] rdata;
  logic        rdv;
  logic        busy, done, pass, timeout_err;
  logic [31:0] id_out, ts_out;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc    = 0;

  logic [31:0] m_id = '0;
  logic [31:0] m_ts = '0;

  soc_system_sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (LIMIT)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (wr),
    .avm_readdata      (rdata),
    .avm_readdatavalid (rdv),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .timeout_err       (timeout_err),
    .id_out            (id_out),
    .ts_out            (ts_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    if (reset_n && avm_read && !wr) acc++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic serve(input logic addr,
                       input int ws,
                       input int lat,
                       input logic resp,
                       input logic [31:0] data);
    int k;
    k = 0;
    while (!avm_read && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("rd_seen", avm_read, 1);
    chk("rd_addr", avm_address, addr);
    for (int i = 0; i < ws; i++) begin
      rdv   = 1'($urandom_range(0, 1));
      rdata = $urandom;
      @(negedge clock);
      chk("ws_hold", {avm_read, avm_address},
          {1'b1, addr});
    end
    wr  = 1'b0;
    rdv = 1'b0;
    if (resp && lat == 0) begin
      rdv   = 1'b1;
      rdata = data;
    end
    @(negedge clock);
    wr    = 1'b1;
    rdv   = 1'b0;
    rdata = $urandom;
    if (lat > 0) begin
      chk("rd_drop", avm_read, 0);
      if (resp) begin
        repeat (lat - 1) @(negedge clock);
        rdv   = 1'b1;
        rdata = data;
        @(negedge clock);
        rdv   = 1'b0;
        rdata = $urandom;
      end
    end
  endtask

  task automatic kick(input logic dbl);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_set", busy, 1);
    chk("clr_res", {pass, timeout_err}, 0);
    if (dbl) begin
      start = 1'b1;
      fork
        begin
          @(negedge clock);
          start = 1'b0;
        end
      join_none
    end
  endtask

  task automatic run_check(input logic [31:0] id,
                           input logic [31:0] ts,
                           input int ws,
                           input int lat,
                           input logic r_id,
                           input logic r_ts,
                           input logic dbl);
    int   t0, dt, exp_dt, exp_acc, k;
    logic exp_to, exp_pass;
    exp_to = !r_id || (TS_EN && !r_ts);
    if (r_id) m_id = id;
    if (TS_EN && r_id && r_ts) m_ts = ts;
    exp_pass = !exp_to && (m_id == EXP_ID) &&
               (!TS_EN || m_ts == EXP_TS);
    exp_dt = 1 + (r_id ? ws + 1 + lat : LIMIT);
    if (TS_EN && r_id)
      exp_dt += r_ts ? ws + 1 + lat : LIMIT;
    exp_acc = (TS_EN && r_id) ? 2 : 1;

    @(negedge clock);
    acc = 0;
    t0  = cyc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_set", busy, 1);
    chk("clr_res", {pass, timeout_err}, 0);
    if (dbl) begin
      start = 1'b1;
      fork
        begin
          @(negedge clock);
          start = 1'b0;
        end
      join_none
    end
    serve(1'b0, ws, lat, r_id, id);
    if (TS_EN && r_id) serve(1'b1, ws, lat, r_ts, ts);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("done_seen", done, 1);
    dt = cyc - t0;
    chk("latency", dt, exp_dt);
    chk("tmo_err", timeout_err, exp_to);
    chk("accepts", acc, exp_acc);
    @(negedge clock);
    chk("done_1cyc", {done, busy}, 0);
    chk("pass", pass, exp_pass);
    chk("tmo_hold", timeout_err, exp_to);
    chk("id_out", id_out, m_id);
    chk("ts_out", ts_out, m_ts);
  endtask

  task automatic reset_mid();
    kick(1'b1);
    if (TS_EN) begin
      serve(1'b0, 0, 1, 1'b1, EXP_ID);
      serve(1'b1, 1, 1, 1'b0, 32'h0);
    end else begin
      serve(1'b0, 1, 1, 1'b0, 32'h0);
    end
    @(negedge clock);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_ctl",
        {avm_read, avm_address, busy, done,
         pass, timeout_err}, 0);
    chk("rst_id", id_out, 0);
    chk("rst_ts", ts_out, 0);
    m_id = '0;
    m_ts = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    rdv   = 1'b1;
    rdata = EXP_ID;
    @(negedge clock);
    rdv = 1'b0;
    @(negedge clock);
    chk("late_ctl", {busy, avm_read, done}, 0);
    chk("late_id", id_out, 0);
  endtask

  initial begin
    logic [31:0] rid, rts;
    reset_n = 1'b0;
    start   = 1'b0;
    wr      = 1'b1;
    rdv     = 1'b0;
    rdata   = '0;
    repeat (3) @(negedge clock);
    chk("rst_ctl0",
        {avm_read, avm_address, busy, done,
         pass, timeout_err}, 0);
    chk("rst_data0", {id_out, ts_out}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle0", {busy, done, avm_read}, 0);

    run_check(EXP_ID, EXP_TS, 0, 1, 1, 1, 0);
    run_check(32'h1234_5678, EXP_TS, 0, 1, 1, 1, 0);
    run_check(EXP_ID, EXP_TS, 3, 1, 1, 1, 0);
    run_check(EXP_ID, EXP_TS, 0, 1, 0, 1, 0);
    run_check(EXP_ID, EXP_TS, 0, 0, 1, 1, 1);
    run_check(EXP_ID, 32'hDEAD_0001, 2, 3, 1, 1, 0);

    @(negedge clock);
    rdv   = 1'b1;
    rdata = 32'hFFFF_0000;
    @(negedge clock);
    rdv = 1'b0;
    @(negedge clock);
    chk("stray_idle", {id_out, ts_out}, {m_id, m_ts});

    reset_mid();
    run_check(EXP_ID, EXP_TS, 1, 2, 1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      rid = ($urandom_range(0, 1) != 0) ?
            EXP_ID : $urandom;
      rts = ($urandom_range(0, 1) != 0) ?
            EXP_TS : $urandom;
      run_check(rid, rts,
                $urandom_range(0, 3),
                $urandom_range(0, 3),
                1'($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
